// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the round-robin Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ABORT
   } arb_state_e;

   localparam int MAX_MASTERS = 8;

   // Number of unacknowledged strobe cycles after which an access is aborted.
   function automatic int wdog_limit(input int tw);
      return (1 << tw) - 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - multi-master Wishbone bus bundle around the arbiter
interface wb_rr_arbiter_if #(
   parameter int MASTERS = 2,
   parameter int AW      = 30
);
   logic [MASTERS-1:0]      m_cyc_i;
   logic [MASTERS-1:0]      m_stb_i;
   logic [MASTERS-1:0]      m_we_i;
   logic [4*MASTERS-1:0]    m_sel_i;
   logic [AW*MASTERS-1:0]   m_adr_i;
   logic [32*MASTERS-1:0]   m_dat_i;
   logic [MASTERS-1:0]      m_ack_o;
   logic [MASTERS-1:0]      m_err_o;
   logic [31:0]             m_dat_o;
   logic                    s_cyc_o;
   logic                    s_stb_o;
   logic                    s_we_o;
   logic [3:0]              s_sel_o;
   logic [AW-1:0]           s_adr_o;
   logic [31:0]             s_dat_o;
   logic                    s_ack_i;
   logic [31:0]             s_dat_i;
   logic [MASTERS-1:0]      grant_o;

   // slave is the arbiter's own view; master is the surrounding masters plus peripheral
   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
      output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
             s_dat_o, grant_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
      input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
             s_dat_o, grant_o
   );

endinterface

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick of the first requester after ptr
module rr_select #(
   parameter int MASTERS = 2,
   parameter int IW      = 1
) (
   input  logic [MASTERS-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [MASTERS-1:0] gnt_o,
   output logic [IW-1:0]      idx_o,
   output logic               valid_o
);
   logic [IW-1:0] cand;

   // Scan from farthest to nearest so the nearest requester after ptr is written last.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = MASTERS; k >= 1; k--) begin
         cand = IW'((int'(ptr_i) + k) % MASTERS);
         if (req_i[cand]) begin
            gnt_o       = '0;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone classic arbiter with per-access watchdog
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int MASTERS = 2,
   parameter int AW      = 30,
   parameter int TW      = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   wb_rr_arbiter_if.slave bus
);
   localparam int            IW         = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam logic [TW-1:0] WDOG_LIMIT = TW'(wdog_limit(TW));

   arb_state_e         state_q;
   logic [MASTERS-1:0] grant_q;
   logic [MASTERS-1:0] err_q;
   logic [IW-1:0]      gidx_q;
   logic [IW-1:0]      ptr_q;
   logic [TW-1:0]      wdog_q;
   logic [TW-1:0]      wdog_d;

   logic [MASTERS-1:0] pick_onehot;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;
   logic               busy;
   logic               g_cyc;
   logic               g_stb;

   rr_select #(
      .MASTERS (MASTERS),
      .IW      (IW)
   ) u_sel (
      .req_i   (bus.m_cyc_i),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_onehot),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign busy   = (state_q == BUSY);
   assign g_cyc  = bus.m_cyc_i[gidx_q];
   assign g_stb  = bus.m_stb_i[gidx_q];
   assign wdog_d = wdog_q + 1'b1;

   // Slave side follows the registered grant with no added latency; forced low outside BUSY.
   assign bus.s_cyc_o = busy & g_cyc;
   assign bus.s_stb_o = busy & g_stb;
   assign bus.s_we_o  = busy & bus.m_we_i[gidx_q];
   assign bus.s_sel_o = busy ? bus.m_sel_i[4*gidx_q +: 4]   : '0;
   assign bus.s_adr_o = busy ? bus.m_adr_i[AW*gidx_q +: AW] : '0;
   assign bus.s_dat_o = busy ? bus.m_dat_i[32*gidx_q +: 32] : '0;

   assign bus.m_ack_o = (busy & bus.s_ack_i) ? grant_q : '0;
   assign bus.m_err_o = err_q;
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.grant_o = grant_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         err_q   <= '0;
         gidx_q  <= '0;
         ptr_q   <= IW'(MASTERS - 1);
         wdog_q  <= '0;
      end else begin
         err_q <= '0;
         case (state_q)
            IDLE: begin
               wdog_q <= '0;
               if (pick_valid) begin
                  grant_q <= pick_onehot;
                  gidx_q  <= pick_idx;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (!g_cyc) begin
                  ptr_q   <= gidx_q;
                  grant_q <= '0;
                  state_q <= IDLE;
               end else if (bus.s_ack_i) begin
                  wdog_q <= '0;
               end else if (g_stb) begin
                  wdog_q <= wdog_d;
                  if (wdog_d == WDOG_LIMIT) begin
                     err_q   <= grant_q;
                     state_q <= ABORT;
                  end
               end
            end
            ABORT: begin
               // Hold the grant until the aborted master gives up its cycle.
               if (!g_cyc) begin
                  ptr_q   <= gidx_q;
                  grant_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed and randomized check of wb_rr_arbiter against a reference model
module tb_wb_rr_arbiter;
   localparam int M     = 2;
   localparam int AW    = 30;
   localparam int TW    = 4;
   localparam int LIMIT = (1 << TW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_rr_arbiter_if #(.MASTERS(M), .AW(AW)) bus ();

   wb_rr_arbiter #(
      .MASTERS (M),
      .AW      (AW),
      .TW      (TW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   logic [M-1:0]  cyc, stb, we;
   logic [3:0]    sel [M];
   logic [AW-1:0] adr [M];
   logic [31:0]   dat [M];
   logic          s_ack;
   logic [31:0]   s_dat;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: owner index (-1 when idle), abort flag, last owner, unacked strobe count.
   int own, last, waitc, err_now;
   bit aborted;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      own = -1; last = M - 1; waitc = 0; err_now = -1; aborted = 0;
   endtask

   task automatic apply();
      bus.m_cyc_i = cyc;
      bus.m_stb_i = stb;
      bus.m_we_i  = we;
      for (int i = 0; i < M; i++) begin
         bus.m_sel_i[4*i +: 4]   = sel[i];
         bus.m_adr_i[AW*i +: AW] = adr[i];
         bus.m_dat_i[32*i +: 32] = dat[i];
      end
      bus.s_ack_i = s_ack;
      bus.s_dat_i = s_dat;
   endtask

   task automatic check_outputs();
      logic [M-1:0] eg, ea, ee;
      bit act;
      int o;
      o   = (own < 0) ? 0 : own;
      act = (own >= 0) && !aborted;
      eg = '0; ea = '0; ee = '0;
      if (own >= 0) eg[o] = 1'b1;
      if (act && s_ack) ea[o] = 1'b1;
      if (err_now >= 0) ee[err_now] = 1'b1;
      chk_eq("grant",  bus.grant_o, eg);
      chk_eq("m_ack",  bus.m_ack_o, ea);
      chk_eq("m_err",  bus.m_err_o, ee);
      chk_eq("m_dat",  bus.m_dat_o, s_dat);
      chk_eq("s_cyc",  bus.s_cyc_o, act ? cyc[o] : 1'b0);
      chk_eq("s_stb",  bus.s_stb_o, act ? stb[o] : 1'b0);
      chk_eq("s_we",   bus.s_we_o,  act ? we[o]  : 1'b0);
      chk_eq("s_sel",  bus.s_sel_o, act ? sel[o] : 4'h0);
      chk_eq("s_adr",  bus.s_adr_o, act ? adr[o] : '0);
      chk_eq("s_dat",  bus.s_dat_o, act ? dat[o] : 32'h0);
   endtask

   task automatic model_step();
      int nerr;
      nerr = -1;
      if (own < 0) begin
         for (int k = 1; k <= M; k++)
            if (own < 0 && cyc[(last + k) % M]) own = (last + k) % M;
         aborted = 0;
         waitc   = 0;
      end else if (!cyc[own]) begin
         last  = own;
         own   = -1;
         waitc = 0;
      end else if (!aborted) begin
         if (s_ack) waitc = 0;
         else if (stb[own]) begin
            waitc++;
            if (waitc == LIMIT) begin
               nerr    = own;
               aborted = 1;
            end
         end
      end
      err_now = nerr;
   endtask

   task automatic drive_and_check();
      apply();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic step();
      drive_and_check();
      advance();
   endtask

   int len [M];
   int ack_pct;
   int acks;

   initial begin
      cyc = '0; stb = '0; we = '0; s_ack = 1'b0; s_dat = '0;
      for (int i = 0; i < M; i++) begin
         sel[i] = '0; adr[i] = '0; dat[i] = '0; len[i] = 0;
      end
      model_reset();
      apply();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1 rst = 1'b0;

      // Simultaneous requests: master 0 first, master 1 after one dead cycle.
      cyc = 2'b11;
      step();
      chk_eq("first_grant", bus.grant_o, 2'b01);
      step(); step();
      cyc = 2'b10;
      step();
      chk_eq("dead_cycle", bus.grant_o, 2'b00);
      step();
      chk_eq("second_grant", bus.grant_o, 2'b10);

      // Single read by master 0.
      cyc = 2'b00;
      step();
      cyc = 2'b01; stb = 2'b01; we = 2'b00; sel[0] = 4'hF; adr[0] = 30'h0040_0001;
      step();
      s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
      drive_and_check();
      chk_eq("read_ack", bus.m_ack_o, 2'b01);
      chk_eq("read_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      chk_eq("read_adr", bus.s_adr_o, 30'h0040_0001);
      advance();
      cyc = 2'b00; stb = 2'b00; s_ack = 1'b0;
      step();

      // Master 1 write burst; master 0 waits.
      cyc = 2'b10;
      step();
      cyc = 2'b11; stb = 2'b10; we = 2'b10; s_ack = 1'b1; acks = 0;
      for (int b = 0; b < 4; b++) begin
         adr[1] = 30'h100 + 30'(b); dat[1] = 32'hA000_0000 + 32'(b);
         drive_and_check();
         if (bus.m_ack_o == 2'b10) acks++;
         chk_eq("burst_grant", bus.grant_o, 2'b10);
         chk_eq("burst_wdat", bus.s_dat_o, 32'hA000_0000 + 32'(b));
         advance();
      end
      chk_eq("burst_acks", acks, 4);
      cyc = 2'b01; stb = 2'b00; we = 2'b00; s_ack = 1'b0;
      step();
      step();
      chk_eq("waiter_grant", bus.grant_o, 2'b01);

      // Watchdog timeout on master 0.
      stb = 2'b01;
      for (int c = 0; c < LIMIT; c++) begin
         drive_and_check();
         chk_eq("wd_no_err", bus.m_err_o, 2'b00);
         advance();
      end
      drive_and_check();
      chk_eq("wd_err", bus.m_err_o, 2'b01);
      chk_eq("wd_cyc_low", bus.s_cyc_o, 1'b0);
      advance();
      drive_and_check();
      chk_eq("wd_err_pulse", bus.m_err_o, 2'b00);
      s_ack = 1'b1;
      drive_and_check();
      chk_eq("abort_no_ack", bus.m_ack_o, 2'b00);
      advance();
      s_ack = 1'b0; cyc = 2'b00; stb = 2'b00;
      step();
      step();

      // Ack on the last permitted strobe cycle.
      cyc = 2'b01; stb = 2'b01;
      step();
      for (int c = 0; c < LIMIT - 1; c++) step();
      s_ack = 1'b1;
      drive_and_check();
      chk_eq("late_ack", bus.m_ack_o, 2'b01);
      advance();
      s_ack = 1'b0;
      drive_and_check();
      chk_eq("late_no_err", bus.m_err_o, 2'b00);
      chk_eq("late_cyc", bus.s_cyc_o, 1'b1);
      advance();
      cyc = 2'b00; stb = 2'b00;
      step();

      // Reset in the middle of a master 1 burst.
      cyc = 2'b10; stb = 2'b10; we = 2'b10; s_ack = 1'b1;
      step(); step();
      apply();
      #2 rst = 1'b1;
      #1;
      chk_eq("rst_cyc", bus.s_cyc_o, 1'b0);
      chk_eq("rst_grant", bus.grant_o, 2'b00);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc = 2'b11; stb = 2'b00; s_ack = 1'b0;
      step();
      chk_eq("rst_first", bus.grant_o, 2'b01);
      cyc = 2'b00;
      step();

      // Randomized traffic with varying slave responsiveness.
      ack_pct = 50;
      for (int n = 0; n < 2000; n++) begin
         if (n % 50 == 0) begin
            case ($urandom_range(3))
               0: ack_pct = 0;
               1: ack_pct = 10;
               2: ack_pct = 50;
               default: ack_pct = 100;
            endcase
         end
         for (int i = 0; i < M; i++) begin
            if (len[i] == 0 && $urandom_range(99) < 30) len[i] = $urandom_range(1, 30);
            cyc[i] = (len[i] > 0);
            if (len[i] > 0) len[i]--;
            stb[i] = cyc[i] && ($urandom_range(99) < 80);
            we[i]  = 1'($urandom);
            sel[i] = 4'($urandom);
            adr[i] = AW'($urandom);
            dat[i] = $urandom;
         end
         s_ack = ($urandom_range(99) < ack_pct);
         s_dat = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
